// File: rtl/decode_thread_scheduler.sv
// Round-robin scheduler feeding one decoder from per-thread instruction FIFOs.
// Define FD_SCHED_PERF_EN to add saturating stall/bubble performance counters.
module decode_thread_scheduler #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int numThreads              = 2,
    parameter int fifoDepth               = 2
) (
    input  logic                                   clock_i,
    input  logic                                   reset_i,
    input  logic [numThreads-1:0]                  thrValid_i,
    output logic [numThreads-1:0]                  thrReady_o,
    input  logic [numThreads-1:0]                  thrFlush_i,
    input  logic [numThreads*instructionWidth-1:0] thrInstruction_i,
    input  logic [numThreads*addressWidth-1:0]     thrAddress_i,
    input  logic [numThreads*PidSize-1:0]          thrPid_i,
    input  logic [numThreads*TidSize-1:0]          thrTid_i,
    input  logic                                   stall_i,
    output logic                                   enable_o,
    output logic [instructionWidth-1:0]            instruction_o,
    output logic [addressWidth-1:0]                instructionAddress_o,
    output logic [PidSize-1:0]                     instructionPid_o,
    output logic [TidSize-1:0]                     instructionTid_o,
    output logic [instructionCounterWidth-1:0]     instructionMajId_o,
    output logic [1:0]                             threadSel_o
`ifdef FD_SCHED_PERF_EN
    ,
    output logic [31:0]                            stallCycles_o,
    output logic [31:0]                            bubbleCycles_o
`endif
);

    localparam int PTR_W   = $clog2(fifoDepth);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = instructionWidth + addressWidth + PidSize + TidSize;

    typedef struct packed {
        logic [instructionWidth-1:0] instruction;
        logic [addressWidth-1:0]     address;
        logic [PidSize-1:0]          pid;
        logic [TidSize-1:0]          tid;
    } entry_t;

    logic [numThreads-1:0]         nonempty;
    logic [numThreads-1:0]         eligible;
    logic [numThreads*ENTRY_W-1:0] head_flat;
    logic [1:0]                    rr_ptr;
    logic                          grant_valid;
    logic [1:0]                    grant_idx;
    entry_t                        grant_entry;
    logic                          flush_current;
    logic [instructionCounterWidth-1:0] maj_id;

    for (genvar t = 0; t < numThreads; t++) begin : g_thread
        entry_t             mem [fifoDepth];
        entry_t             in_entry;
        logic [PTR_W-1:0]   wr_ptr;
        logic [PTR_W-1:0]   rd_ptr;
        logic [CNT_W-1:0]   count;
        logic               push;
        logic               pop;

        assign in_entry = {thrInstruction_i[t*instructionWidth +: instructionWidth],
                           thrAddress_i[t*addressWidth +: addressWidth],
                           thrPid_i[t*PidSize +: PidSize],
                           thrTid_i[t*TidSize +: TidSize]};

        assign thrReady_o[t] = (count != CNT_W'(fifoDepth));
        assign nonempty[t]   = (count != '0);
        assign eligible[t]   = !stall_i && !thrFlush_i[t] && nonempty[t];
        // Flush wins over both a push and a pop on this thread.
        assign push          = thrValid_i[t] && thrReady_o[t] && !thrFlush_i[t];
        assign pop           = grant_valid && (grant_idx == 2'(t));
        assign head_flat[t*ENTRY_W +: ENTRY_W] = mem[rd_ptr];

        always_ff @(posedge clock_i) begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
            end
        end

        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (thrFlush_i[t]) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // Search starts one past the last granted thread and wraps around.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= numThreads; i++) begin
            for (int t = 0; t < numThreads; t++) begin
                if (!grant_valid && eligible[t] && (t == (int'(rr_ptr) + i) % numThreads)) begin
                    grant_valid = 1'b1;
                    grant_idx   = 2'(t);
                end
            end
        end
    end

    always_comb begin
        grant_entry   = '0;
        flush_current = 1'b0;
        for (int t = 0; t < numThreads; t++) begin
            if (grant_idx == 2'(t)) begin
                grant_entry = head_flat[t*ENTRY_W +: ENTRY_W];
            end
            if ((threadSel_o == 2'(t)) && thrFlush_i[t]) begin
                flush_current = 1'b1;
            end
        end
    end

    // A flush of the thread on the outputs retracts it even while stalled.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            enable_o             <= 1'b0;
            instruction_o        <= '0;
            instructionAddress_o <= '0;
            instructionPid_o     <= '0;
            instructionTid_o     <= '0;
            instructionMajId_o   <= '0;
            threadSel_o          <= '0;
            maj_id               <= '0;
            rr_ptr               <= 2'(numThreads - 1);
        end else if (!stall_i) begin
            if (grant_valid) begin
                enable_o             <= 1'b1;
                instruction_o        <= grant_entry.instruction;
                instructionAddress_o <= grant_entry.address;
                instructionPid_o     <= grant_entry.pid;
                instructionTid_o     <= grant_entry.tid;
                instructionMajId_o   <= maj_id;
                threadSel_o          <= grant_idx;
                maj_id               <= maj_id + instructionCounterWidth'(1);
                rr_ptr               <= grant_idx;
            end else begin
                enable_o <= 1'b0;
            end
        end else if (flush_current) begin
            enable_o <= 1'b0;
        end
    end

`ifdef FD_SCHED_PERF_EN
    logic all_empty;
    assign all_empty = ~|nonempty;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stallCycles_o  <= '0;
            bubbleCycles_o <= '0;
        end else begin
            if (stall_i && enable_o && (stallCycles_o != '1)) begin
                stallCycles_o <= stallCycles_o + 32'd1;
            end
            if (!stall_i && all_empty && (bubbleCycles_o != '1)) begin
                bubbleCycles_o <= bubbleCycles_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_thread_scheduler.sv
// Bench for decode_thread_scheduler: queue-based reference model feeding a scoreboard.
// Perf counter checks are compiled in when FD_SCHED_PERF_EN is defined.
module tb_decode_thread_scheduler;

    localparam int AW = 64;
    localparam int IW = 32;
    localparam int PW = 20;
    localparam int TW = 16;
    localparam int CW = 64;
    localparam int NT = 2;
    localparam int FD = 2;

    logic              clock_i = 1'b0;
    logic              reset_i;
    logic [NT-1:0]     thrValid_i;
    logic [NT-1:0]     thrReady_o;
    logic [NT-1:0]     thrFlush_i;
    logic [NT*IW-1:0]  thrInstruction_i;
    logic [NT*AW-1:0]  thrAddress_i;
    logic [NT*PW-1:0]  thrPid_i;
    logic [NT*TW-1:0]  thrTid_i;
    logic              stall_i;
    logic              enable_o;
    logic [IW-1:0]     instruction_o;
    logic [AW-1:0]     instructionAddress_o;
    logic [PW-1:0]     instructionPid_o;
    logic [TW-1:0]     instructionTid_o;
    logic [CW-1:0]     instructionMajId_o;
    logic [1:0]        threadSel_o;
`ifdef FD_SCHED_PERF_EN
    logic [31:0]       stallCycles_o;
    logic [31:0]       bubbleCycles_o;
`endif

    decode_thread_scheduler #(
        .addressWidth(AW), .instructionWidth(IW), .PidSize(PW), .TidSize(TW),
        .instructionCounterWidth(CW), .numThreads(NT), .fifoDepth(FD)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .thrValid_i(thrValid_i),
        .thrReady_o(thrReady_o),
        .thrFlush_i(thrFlush_i),
        .thrInstruction_i(thrInstruction_i),
        .thrAddress_i(thrAddress_i),
        .thrPid_i(thrPid_i),
        .thrTid_i(thrTid_i),
        .stall_i(stall_i),
        .enable_o(enable_o),
        .instruction_o(instruction_o),
        .instructionAddress_o(instructionAddress_o),
        .instructionPid_o(instructionPid_o),
        .instructionTid_o(instructionTid_o),
        .instructionMajId_o(instructionMajId_o),
        .threadSel_o(threadSel_o)
`ifdef FD_SCHED_PERF_EN
        ,
        .stallCycles_o(stallCycles_o),
        .bubbleCycles_o(bubbleCycles_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] addr;
        logic [PW-1:0] pid;
        logic [TW-1:0] tid;
        logic [CW-1:0] majId;
        logic [1:0]    sel;
    } item_t;

    int     checks = 0;
    int     errors = 0;

    item_t  modelFifo [NT][$];
    item_t  expQ [$];
    item_t  newItem;
    item_t  held;
    item_t  got;
    logic   modelEn;
    int     modelSel;
    int     modelRr;
    logic [CW-1:0] modelId;
    bit     lastStall;
    bit     readyBefore [NT];
    bit     modelAllEmpty;
    int     granted;
    int     cand;
    logic [31:0] modelStallCnt;
    logic [31:0] modelBubbleCnt;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareItem(input item_t e);
        checkOutput("instruction", 64'(instruction_o), 64'(e.instr));
        checkOutput("address", instructionAddress_o, e.addr);
        checkOutput("pid", 64'(instructionPid_o), 64'(e.pid));
        checkOutput("tid", 64'(instructionTid_o), 64'(e.tid));
        checkOutput("majId", instructionMajId_o, e.majId);
        checkOutput("threadSel", 64'(threadSel_o), 64'(e.sel));
    endtask

    // Reference model: per-thread queues, a round-robin pointer and an ID counter.
    always @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int t = 0; t < NT; t++) modelFifo[t].delete();
            expQ.delete();
            modelEn        = 1'b0;
            modelSel       = 0;
            modelRr        = NT - 1;
            modelId        = '0;
            lastStall      = 1'b0;
            held           = '0;
            modelStallCnt  = '0;
            modelBubbleCnt = '0;
        end else begin
            modelAllEmpty = 1'b1;
            for (int t = 0; t < NT; t++) begin
                readyBefore[t] = modelFifo[t].size() < FD;
                if (modelFifo[t].size() != 0) modelAllEmpty = 1'b0;
            end
            if (stall_i && modelEn && modelStallCnt != 32'hFFFF_FFFF) modelStallCnt++;
            if (!stall_i && modelAllEmpty && modelBubbleCnt != 32'hFFFF_FFFF) modelBubbleCnt++;

            granted = -1;
            if (!stall_i) begin
                for (int k = 1; k <= NT; k++) begin
                    cand = (modelRr + k) % NT;
                    if (granted < 0 && !thrFlush_i[cand] && modelFifo[cand].size() > 0) granted = cand;
                end
            end
            for (int t = 0; t < NT; t++) begin
                if (thrFlush_i[t]) modelFifo[t].delete();
            end
            if (granted >= 0) begin
                newItem       = modelFifo[granted].pop_front();
                newItem.majId = modelId;
                newItem.sel   = 2'(granted);
                expQ.push_back(newItem);
                modelId++;
                modelRr  = granted;
                modelSel = granted;
                modelEn  = 1'b1;
            end else if (!stall_i) begin
                modelEn = 1'b0;
            end else if (modelEn && thrFlush_i[modelSel]) begin
                modelEn = 1'b0;
            end
            for (int t = 0; t < NT; t++) begin
                if (thrValid_i[t] && readyBefore[t] && !thrFlush_i[t]) begin
                    newItem       = '0;
                    newItem.instr = thrInstruction_i[t*IW +: IW];
                    newItem.addr  = thrAddress_i[t*AW +: AW];
                    newItem.pid   = thrPid_i[t*PW +: PW];
                    newItem.tid   = thrTid_i[t*TW +: TW];
                    modelFifo[t].push_back(newItem);
                end
            end
            lastStall = stall_i;
        end
    end

    // Monitor: a fresh issue pops the scoreboard; a stalled issue must hold.
    always @(negedge clock_i) begin
        if (!reset_i) begin
            for (int t = 0; t < NT; t++) begin
                checkOutput("thrReady", 64'(thrReady_o[t]), 64'(modelFifo[t].size() < FD));
            end
            checkOutput("enable", 64'(enable_o), 64'(modelEn));
            if (enable_o) begin
                if (!lastStall) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL issue: actual unexpected issue required none at %0t", $time);
                    end else begin
                        got  = expQ.pop_front();
                        held = got;
                        compareItem(got);
                    end
                end else begin
                    compareItem(held);
                end
            end
`ifdef FD_SCHED_PERF_EN
            checkOutput("stallCycles", 64'(stallCycles_o), 64'(modelStallCnt));
            checkOutput("bubbleCycles", 64'(bubbleCycles_o), 64'(modelBubbleCnt));
`endif
        end
    end

    task automatic applyStimulus(input logic [NT-1:0] valid, input logic [NT-1:0] flush,
                                 input logic stall, input bit randData = 1'b1);
        if (randData) begin
            for (int t = 0; t < NT; t++) begin
                thrInstruction_i[t*IW +: IW] = $urandom();
                thrAddress_i[t*AW +: AW]     = {$urandom(), $urandom()};
                thrPid_i[t*PW +: PW]         = PW'($urandom());
                thrTid_i[t*TW +: TW]         = TW'($urandom());
            end
        end
        thrValid_i = valid;
        thrFlush_i = flush;
        stall_i    = stall;
        @(posedge clock_i);
        #2;
    endtask

    task automatic doReset();
        reset_i    = 1'b1;
        thrValid_i = '0;
        thrFlush_i = '0;
        stall_i    = 1'b0;
        @(posedge clock_i);
        #2;
        checkOutput("rstEnable", 64'(enable_o), 64'd0);
        checkOutput("rstInstruction", 64'(instruction_o), 64'd0);
        checkOutput("rstAddress", instructionAddress_o, 64'd0);
        checkOutput("rstMajId", instructionMajId_o, 64'd0);
        checkOutput("rstThreadSel", 64'(threadSel_o), 64'd0);
        checkOutput("rstReady", 64'(thrReady_o), 64'({NT{1'b1}}));
        reset_i = 1'b0;
    endtask

`ifdef FD_SCHED_PERF_EN
    logic [31:0] stallBase;
    logic [31:0] bubbleBase;
`endif

    initial begin
        thrInstruction_i = '0;
        thrAddress_i     = '0;
        thrPid_i         = '0;
        thrTid_i         = '0;
        doReset();

        // Single push reaches the outputs one edge after it is captured.
        thrInstruction_i[IW-1:0] = 32'h4800_0010;
        thrAddress_i[AW-1:0]     = 64'h1000;
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        checkOutput("t1Enable", 64'(enable_o), 64'd1);
        checkOutput("t1Instruction", 64'(instruction_o), 64'h4800_0010);
        checkOutput("t1Address", instructionAddress_o, 64'h1000);
        checkOutput("t1MajId", instructionMajId_o, 64'd0);
        checkOutput("t1ThreadSel", 64'(threadSel_o), 64'd0);

        // Round-robin between two full FIFOs.
        doReset();
        applyStimulus(2'b11, 2'b00, 1'b1);
        applyStimulus(2'b11, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b00, 2'b00, 1'b0);
            checkOutput("rrThreadSel", 64'(threadSel_o), 64'(i % 2));
            checkOutput("rrMajId", instructionMajId_o, 64'(i));
        end
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("rrEnableFalls", 64'(enable_o), 64'd0);

        // Backpressure: hold under stall, drop pushes into full FIFOs.
        doReset();
        applyStimulus(2'b01, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(2'b11, 2'b00, 1'b1);
        checkOutput("bpReady", 64'(thrReady_o), 64'd0);
        checkOutput("bpHoldMajId", instructionMajId_o, 64'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b00, 2'b00, 1'b0);
            checkOutput("bpEnable", 64'(enable_o), 64'd1);
            checkOutput("bpMajId", instructionMajId_o, 64'(i + 1));
        end
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("bpDrained", 64'(enable_o), 64'd0);

        // Flush of the thread on the outputs while stalled.
        doReset();
        applyStimulus(2'b10, 2'b00, 1'b0);
        applyStimulus(2'b01, 2'b00, 1'b0);
        checkOutput("flThreadSel", 64'(threadSel_o), 64'd1);
        applyStimulus(2'b01, 2'b00, 1'b1);
        applyStimulus(2'b00, 2'b10, 1'b1);
        checkOutput("flEnable", 64'(enable_o), 64'd0);
        checkOutput("flReady1", 64'(thrReady_o[1]), 64'd1);
        applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("flNextMajId", instructionMajId_o, 64'd1);
        checkOutput("flNextSel", 64'(threadSel_o), 64'd0);
        applyStimulus(2'b00, 2'b00, 1'b0);

        // Push and pop on the same FIFO every cycle.
        doReset();
        applyStimulus(2'b01, 2'b00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'b01, 2'b00, 1'b0);
            checkOutput("ppMajId", instructionMajId_o, 64'(i));
            checkOutput("ppReady", 64'(thrReady_o[0]), 64'd1);
        end
        applyStimulus(2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 1'b0);

`ifdef FD_SCHED_PERF_EN
        doReset();
        applyStimulus(2'b01, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 1'b0);
        stallBase  = stallCycles_o;
        bubbleBase = bubbleCycles_o;
        for (int i = 0; i < 3; i++) applyStimulus(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(2'b00, 2'b00, 1'b0);
        checkOutput("perfStall", 64'(stallCycles_o - stallBase), 64'd3);
        checkOutput("perfBubble", 64'(bubbleCycles_o - bubbleBase), 64'd4);
`endif

        // Randomised traffic with an asynchronous reset partway through.
        doReset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset();
            applyStimulus(NT'($urandom()),
                          {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)},
                          ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 8; i++) applyStimulus(2'b00, 2'b00, 1'b0);
        @(negedge clock_i);
        #1;
        checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
